commit_trace_monitor: RTL and testbench

//   Parametrised architectural-state tracer for the RISC-V core.
//   - Sits beside the datapath and snoops one retirement per cycle: PC, rd index, rd data, write enable.
//   - Packs each qualifying commit into a timestamped record, buffers it in a FIFO, and streams it out over valid/ready.
//   - Detects program end (PC self-loop) or cycle timeout, then drains the FIFO and raises done.
//   - Replaces per-cycle register dumps with a bounded, filterable, synthesizable trace.

---
 rtl/commit_trace_monitor.sv | 199 +++++++++++++++++++
 tb/tb_commit_trace_monitor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_monitor.sv
// commit_trace_monitor
//   Architectural-state tracer that sits beside the core datapath. It snoops
//   one retirement per cycle, packs each qualifying commit into a timestamped
//   record {cycle, pc, rd, data}, buffers it in a FIFO and streams it out.
//   Tracing starts on enable. It stops on a PC self-loop (halt) or a cycle
//   timeout. The FIFO then drains, and the block parks in DONE.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   enable          start tracing; only looked at while IDLE
//   commit_*        retirement snoop: valid, pc, rd index, write enable, data
//   out_valid/out_ready/out_record   record stream
//   cycle_count     RUN cycles elapsed, saturating
//   overflow        sticky, a record was dropped; drop_count counts the drops
//   halted/timeout  sticky stop causes
//   done            FSM is in DONE
//   dbg_state       current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Handshake: a record transfers on every rising edge where out_valid and
// out_ready are both high. While out_valid=1 and out_ready=0, out_record holds
// its value. out_valid never drops without a transfer, except on reset.
module commit_trace_monitor #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int DEPTH       = 16,
  parameter int CYC_W       = 32,
  parameter int MAX_CYCLES  = 500,
  parameter int HALT_REPEAT = 3,
  parameter int MODE        = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              commit_valid,
  input  logic [XLEN-1:0]                   commit_pc,
  input  logic [REG_AW-1:0]                 commit_rd,
  input  logic                              commit_we,
  input  logic [XLEN-1:0]                   commit_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CYC_W+XLEN+REG_AW+XLEN-1:0] out_record,
  output logic [CYC_W-1:0]                  cycle_count,
  output logic                              overflow,
  output logic [15:0]                       drop_count,
  output logic                              halted,
  output logic                              timeout,
  output logic                              done,
  output logic [1:0]                        dbg_state
);

  localparam int REC_W = CYC_W + XLEN + REG_AW + XLEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CYC_W-1:0]   r_cycle;
  logic [XLEN-1:0]    r_last_pc;
  logic [31:0]        r_rep;
  logic               r_overflow;
  logic [15:0]        r_drop;
  logic               r_halted;
  logic               r_timeout;

  logic [REC_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic               w_run;
  logic               w_commit;
  logic               w_writes;
  logic               w_qualify;
  logic [31:0]        w_rep_nxt;
  logic               w_halt_fire;
  logic               w_timeout_fire;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [REC_W-1:0]   w_rec;

  assign w_run    = (r_state == S_RUN);
  assign w_commit = w_run && commit_valid;
  // A commit writes architectural state only if rd is not x0.
  assign w_writes = commit_we && (commit_rd != '0);
  assign w_qualify = w_commit && ((MODE != 0) || w_writes);

  // Repeat count for the PC currently being retired. After reset, r_rep=0, so
  // a first commit at PC 0 still counts as 1.
  always_comb begin
    w_rep_nxt = 32'd1;
    if (commit_pc == r_last_pc) begin
      w_rep_nxt = (r_rep == '1) ? r_rep : r_rep + 32'd1;
    end
  end

  assign w_halt_fire    = (HALT_REPEAT != 0) && w_commit && (w_rep_nxt == 32'(HALT_REPEAT));
  assign w_timeout_fire = (MAX_CYCLES != 0) && w_run && (r_cycle == TO_LAST);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = out_valid && out_ready;
  // When full, a push is accepted only if a pop frees the head slot in the same cycle.
  assign w_push  = w_qualify && (!w_full || w_pop);
  assign w_drop  = w_qualify && w_full && !w_pop;

  assign w_rec = {r_cycle, commit_pc,
                  w_writes ? commit_rd : {REG_AW{1'b0}},
                  w_writes ? commit_data : {XLEN{1'b0}}};

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (w_halt_fire || w_timeout_fire) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Cycle counter, halt tracking and sticky status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle    <= '0;
      r_last_pc  <= '0;
      r_rep      <= '0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
      r_halted   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_run && (r_cycle != '1)) r_cycle <= r_cycle + 1'b1;
      if (w_commit) begin
        r_last_pc <= commit_pc;
        r_rep     <= w_rep_nxt;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
      if (w_halt_fire)    r_halted  <= 1'b1;
      if (w_timeout_fire) r_timeout <= 1'b1;
    end
  end

  // FIFO storage holds no reset state. Entries are only visible through the
  // read pointer while the count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid   = !w_empty;
  assign out_record  = w_empty ? {REC_W{1'b0}} : r_mem[r_rd_ptr];
  assign cycle_count = r_cycle;
  assign overflow    = r_overflow;
  assign drop_count  = r_drop;
  assign halted      = r_halted;
  assign timeout     = r_timeout;
  assign done        = (r_state == S_DONE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Directed bench for commit_trace_monitor.
// u_dut0 is configured with MODE 0 and u_dut1 with MODE 1. Both share the stimulus.
// The configuration is DEPTH=4, MAX_CYCLES=10 and HALT_REPEAT=3.
module tb_commit_trace_monitor;

  localparam int XLEN  = 32;
  localparam int RAW   = 5;
  localparam int CYC_W = 32;
  localparam int REC_W = CYC_W + XLEN + RAW + XLEN;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             c_valid;
  logic [XLEN-1:0]  c_pc;
  logic [RAW-1:0]   c_rd;
  logic             c_we;
  logic [XLEN-1:0]  c_data;
  logic             out_ready;

  logic             o0_valid, o1_valid;
  logic [REC_W-1:0] o0_rec, o1_rec;
  logic [CYC_W-1:0] o0_cyc, o1_cyc;
  logic             o0_ovf, o1_ovf;
  logic [15:0]      o0_drop, o1_drop;
  logic             o0_halt, o1_halt;
  logic             o0_to, o1_to;
  logic             o0_done, o1_done;
  logic [1:0]       o0_st, o1_st;

  int n_vec  = 0;
  int n_fail = 0;

  commit_trace_monitor #(
    .XLEN(XLEN), .REG_AW(RAW), .DEPTH(4), .CYC_W(CYC_W),
    .MAX_CYCLES(10), .HALT_REPEAT(3), .MODE(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable),
    .commit_valid(c_valid), .commit_pc(c_pc), .commit_rd(c_rd),
    .commit_we(c_we), .commit_data(c_data),
    .out_valid(o0_valid), .out_ready(out_ready), .out_record(o0_rec),
    .cycle_count(o0_cyc), .overflow(o0_ovf), .drop_count(o0_drop),
    .halted(o0_halt), .timeout(o0_to), .done(o0_done), .dbg_state(o0_st)
  );

  commit_trace_monitor #(
    .XLEN(XLEN), .REG_AW(RAW), .DEPTH(4), .CYC_W(CYC_W),
    .MAX_CYCLES(10), .HALT_REPEAT(3), .MODE(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable),
    .commit_valid(c_valid), .commit_pc(c_pc), .commit_rd(c_rd),
    .commit_we(c_we), .commit_data(c_data),
    .out_valid(o1_valid), .out_ready(out_ready), .out_record(o1_rec),
    .cycle_count(o1_cyc), .overflow(o1_ovf), .drop_count(o1_drop),
    .halted(o1_halt), .timeout(o1_to), .done(o1_done), .dbg_state(o1_st)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [REC_W-1:0] mk_rec(input logic [31:0] cyc, input logic [31:0] pc,
                                              input logic [4:0] rd, input logic [31:0] data);
    mk_rec = {cyc, pc, rd, data};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    c_valid   = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                        input logic [31:0] data);
    c_valid = 1'b1;
    c_pc    = pc;
    c_rd    = rd;
    c_we    = we;
    c_data  = data;
    tick();
    c_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; c_valid = 1'b0; c_pc = '0; c_rd = '0;
    c_we = 1'b0; c_data = '0; out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_valid",   128'(o0_valid), 128'(0));
    chk("rst_record",  128'(o0_rec),   128'(0));
    chk("rst_cycle",   128'(o0_cyc),   128'(0));
    chk("rst_drop",    128'(o0_drop),  128'(0));
    chk("rst_flags",   128'({o0_ovf, o0_halt, o0_to, o0_done}), 128'(0));
    chk("rst_state",   128'(o0_st),    128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: MODE 0 filters the x0 write; MODE 1 keeps it with rd/data zeroed
    start();
    chk("t1_state_run", 128'(o0_st),  128'(1));
    chk("t1_cycle0",    128'(o0_cyc), 128'(0));
    commit(32'h0, 5'd5, 1'b1, 32'h11);
    commit(32'h4, 5'd0, 1'b1, 32'h22);
    chk("t1_m0_valid",  128'(o0_valid), 128'(1));
    chk("t1_m0_rec",    128'(o0_rec), 128'(mk_rec(0, 32'h0, 5'd5, 32'h11)));
    chk("t1_m1_rec0",   128'(o1_rec), 128'(mk_rec(0, 32'h0, 5'd5, 32'h11)));
    chk("t1_cycle2",    128'(o0_cyc), 128'(2));
    out_ready = 1'b1;
    tick();
    chk("t1_m0_single", 128'(o0_valid), 128'(0));
    chk("t1_m1_valid",  128'(o1_valid), 128'(1));
    chk("t1_m1_rec1",   128'(o1_rec), 128'(mk_rec(1, 32'h4, 5'd0, 32'h0)));
    tick();
    chk("t1_m1_empty",  128'(o1_valid), 128'(0));

    // T2: backpressure, 6 pushes into 4 entries
    do_reset();
    start();
    for (int i = 0; i < 6; i++) commit(32'h100 + 32'(4 * i), 5'(i + 1), 1'b1, 32'h101 + 32'(i));
    chk("t2_overflow", 128'(o0_ovf),  128'(1));
    chk("t2_drop",     128'(o0_drop), 128'(2));
    chk("t2_cycle",    128'(o0_cyc),  128'(6));
    chk("t2_valid",    128'(o0_valid), 128'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_rec%0d", i), 128'(o0_rec),
          128'(mk_rec(32'(i), 32'h100 + 32'(4 * i), 5'(i + 1), 32'h101 + 32'(i))));
      tick();
    end
    chk("t2_drained", 128'(o0_valid), 128'(0));

    // T3: full FIFO with simultaneous pop and push
    do_reset();
    start();
    for (int i = 0; i < 4; i++) commit(32'h200 + 32'(4 * i), 5'(7 + i), 1'b1, 32'h700 + 32'(i));
    chk("t3_full_hold", 128'(o0_rec), 128'(mk_rec(0, 32'h200, 5'd7, 32'h700)));
    out_ready = 1'b1;
    commit(32'h210, 5'd11, 1'b1, 32'h704);
    chk("t3_drop", 128'(o0_drop), 128'(0));
    chk("t3_ovf",  128'(o0_ovf),  128'(0));
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("t3_rec%0d", i), 128'(o0_rec),
          128'(mk_rec(32'(i), 32'h200 + 32'(4 * i), 5'(7 + i), 32'h700 + 32'(i))));
      tick();
    end
    chk("t3_drained", 128'(o0_valid), 128'(0));

    // T4: PC self-loop halt; the record from the halt cycle is still captured
    do_reset();
    start();
    for (int i = 0; i < 3; i++) commit(32'h40, 5'd3, 1'b1, 32'hA);
    chk("t4_halted",  128'(o0_halt), 128'(1));
    chk("t4_drain",   128'(o0_st),   128'(2));
    chk("t4_no_to",   128'(o0_to),   128'(0));
    chk("t4_notdone", 128'(o0_done), 128'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_rec%0d", i), 128'(o0_rec), 128'(mk_rec(32'(i), 32'h40, 5'd3, 32'hA)));
      tick();
    end
    for (int k = 0; k < 6 && !o0_done; k++) tick();
    chk("t4_done",  128'(o0_done), 128'(1));
    chk("t4_state", 128'(o0_st),   128'(3));
    chk("t4_cycle", 128'(o0_cyc),  128'(3));
    enable = 1'b0;
    tick();
    chk("t4_terminal", 128'(o0_st), 128'(3));

    // T5: timeout at cycle_count 9
    do_reset();
    start();
    repeat (9) tick();
    chk("t5_cycle9",  128'(o0_cyc), 128'(9));
    chk("t5_pre_to",  128'(o0_to),  128'(0));
    chk("t5_run",     128'(o0_st),  128'(1));
    tick();
    chk("t5_timeout", 128'(o0_to),   128'(1));
    chk("t5_no_halt", 128'(o0_halt), 128'(0));
    chk("t5_drain",   128'(o0_st),   128'(2));
    tick();
    chk("t5_done",    128'(o0_done), 128'(1));

    // T6: asynchronous reset with 3 records buffered
    do_reset();
    start();
    for (int i = 0; i < 3; i++) commit(32'h300 + 32'(4 * i), 5'(1 + i), 1'b1, 32'h30 + 32'(i));
    chk("t6_valid", 128'(o0_valid), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid_clr", 128'(o0_valid), 128'(0));
    chk("t6_rec_clr",   128'(o0_rec),   128'(0));
    chk("t6_cycle_clr", 128'(o0_cyc),   128'(0));
    chk("t6_idle",      128'(o0_st),    128'(0));
    enable = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_stay_idle", 128'(o0_st),    128'(0));
    chk("t6_still_mt",  128'(o0_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
